// File: rtl/sc_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
package sc_reg_arbiter_pkg;

   // Upper bound on requesters; helpers are sized for this.
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      ACK  = 2'b10
   } arbState_t;

   // Index of the set bit in a one-hot vector (0 when empty).
   function automatic logic [IDX_W-1:0] oneHotToIdx(input logic [MAX_REQ-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(MAX_REQ); i++) begin
         if (vec[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sc_rr_picker.sv
// Round-robin picker: lowest set request at or above the pointer, wrapping.
// Rotates requests down by the pointer, isolates the lowest set bit, rotates back.
module sc_rr_picker #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]                                   req,
   input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]     pointer,
   output logic [NUM_REQ-1:0]                                   winner
);

   logic [2*NUM_REQ-1:0] rotDbl;
   logic [NUM_REQ-1:0]   rotReq;
   logic [NUM_REQ-1:0]   isoReq;
   logic [2*NUM_REQ-1:0] backDbl;

   // Rotate, priority-encode lowest bit, rotate back.
   always_comb begin
      rotDbl  = {req, req} >> pointer;
      rotReq  = rotDbl[NUM_REQ-1:0];
      isoReq  = rotReq & (~rotReq + NUM_REQ'(1));
      backDbl = {isoReq, isoReq} << pointer;
      winner  = backDbl[2*NUM_REQ-1:NUM_REQ];
   end

endmodule

// File: rtl/sc_reg_arbiter.sv
// Round-robin write arbiter and sequencer for a shared register.
// Sequence per write: IDLE (arbitrate) -> LOAD (capture data) -> ACK (pulse ack).
// Optional macro SC_REG_ARBITER_LOCK_EN adds a lock input that keeps the
// current winner at top priority for the next arbitration (burst writes).
module sc_reg_arbiter
   import sc_reg_arbiter_pkg::*;
#(
   parameter int unsigned REG_WIDTH = 4,
   parameter int unsigned NUM_REQ   = 4
) (
   input  logic                         sc_reg_arbiter_CLOCK_50,
   input  logic                         sc_reg_arbiter_RESET_InHigh,
   input  logic [NUM_REQ-1:0]           sc_reg_arbiter_req_InBUS,
   input  logic [NUM_REQ*REG_WIDTH-1:0] sc_reg_arbiter_data_InBUS,
`ifdef SC_REG_ARBITER_LOCK_EN
   input  logic                         sc_reg_arbiter_lock_InHigh,
`endif
   output logic [NUM_REQ-1:0]           sc_reg_arbiter_grant_OutBus,
   output logic [NUM_REQ-1:0]           sc_reg_arbiter_ack_OutBus,
   output logic                         sc_reg_arbiter_busy_OutLow,
   output logic [REG_WIDTH-1:0]         sc_reg_arbiter_z_OutBus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arbState_t            stateQ;
   logic [NUM_REQ-1:0]   grantQ;
   logic [NUM_REQ-1:0]   ackQ;
   logic                 busyQ;
   logic [REG_WIDTH-1:0] zQ;
   logic [PTR_W-1:0]     ptrQ;

   logic [NUM_REQ-1:0]   winner;
   logic [PTR_W-1:0]     winIdx;
   logic [PTR_W-1:0]     nextPtr;
   logic [REG_WIDTH-1:0] winData;
   logic                 lockPtr;

   sc_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) uPicker (
      .req     (sc_reg_arbiter_req_InBUS),
      .pointer (ptrQ),
      .winner  (winner)
   );

`ifdef SC_REG_ARBITER_LOCK_EN
   assign lockPtr = sc_reg_arbiter_lock_InHigh;
`else
   assign lockPtr = 1'b0;
`endif

   // Decode the held grant into an index, its data slice and the following pointer.
   always_comb begin
      winIdx  = PTR_W'(oneHotToIdx(MAX_REQ'(grantQ)));
      winData = sc_reg_arbiter_data_InBUS[int'(winIdx)*REG_WIDTH +: REG_WIDTH];
      if (winIdx == PTR_W'(NUM_REQ - 1)) nextPtr = '0;
      else                               nextPtr = winIdx + PTR_W'(1);
   end

   // FSM with registered grant/ack/busy outputs, shared register and rr pointer.
   always_ff @(posedge sc_reg_arbiter_CLOCK_50 or posedge sc_reg_arbiter_RESET_InHigh) begin
      if (sc_reg_arbiter_RESET_InHigh) begin
         stateQ <= IDLE;
         grantQ <= '0;
         ackQ   <= '0;
         busyQ  <= 1'b1;
         zQ     <= '0;
         ptrQ   <= '0;
      end else begin
         unique case (stateQ)
            IDLE: begin
               ackQ <= '0;
               if (sc_reg_arbiter_req_InBUS != '0) begin
                  grantQ <= winner;
                  busyQ  <= 1'b0;
                  stateQ <= LOAD;
               end
            end
            LOAD: begin
               zQ     <= winData;
               ptrQ   <= lockPtr ? winIdx : nextPtr;
               ackQ   <= grantQ;
               stateQ <= ACK;
            end
            ACK: begin
               grantQ <= '0;
               ackQ   <= '0;
               busyQ  <= 1'b1;
               stateQ <= IDLE;
            end
            default: begin
               grantQ <= '0;
               ackQ   <= '0;
               busyQ  <= 1'b1;
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign sc_reg_arbiter_grant_OutBus = grantQ;
   assign sc_reg_arbiter_ack_OutBus   = ackQ;
   assign sc_reg_arbiter_busy_OutLow  = busyQ;
   assign sc_reg_arbiter_z_OutBus     = zQ;

endmodule

// File: tb/tb_sc_reg_arbiter.sv
// Directed testbench for sc_reg_arbiter (REG_WIDTH=4, NUM_REQ=4).
// Lock scenario is compiled only when SC_REG_ARBITER_LOCK_EN is defined.
module tb_sc_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] data;
   logic        lock;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        busyN;
   logic [3:0]  z;

   int testsRun;
   int testsFailed;

   sc_reg_arbiter #(
      .REG_WIDTH (4),
      .NUM_REQ   (4)
   ) dut (
      .sc_reg_arbiter_CLOCK_50     (clk),
      .sc_reg_arbiter_RESET_InHigh (rst),
      .sc_reg_arbiter_req_InBUS    (req),
      .sc_reg_arbiter_data_InBUS   (data),
`ifdef SC_REG_ARBITER_LOCK_EN
      .sc_reg_arbiter_lock_InHigh  (lock),
`endif
      .sc_reg_arbiter_grant_OutBus (grant),
      .sc_reg_arbiter_ack_OutBus   (ack),
      .sc_reg_arbiter_busy_OutLow  (busyN),
      .sc_reg_arbiter_z_OutBus     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare all four outputs against expected values.
   task automatic expectAll(input string name, input logic [3:0] eGrant, input logic [3:0] eAck,
                            input logic eBusy, input logic [3:0] eZ);
      testsRun++;
      if (grant !== eGrant || ack !== eAck || busyN !== eBusy || z !== eZ) begin
         testsFailed++;
         $display("FAIL %s: got grant=%b ack=%b busy=%b z=%h, want grant=%b ack=%b busy=%b z=%h",
                  name, grant, ack, busyN, z, eGrant, eAck, eBusy, eZ);
      end
   endtask

   task automatic doReset();
      rst  = 1'b1;
      req  = 4'b0000;
      lock = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      data = 16'h0000;
      doReset();
      expectAll("reset", 4'b0000, 4'b0000, 1'b1, 4'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         expectAll($sformatf("reset_idle_%0d", i), 4'b0000, 4'b0000, 1'b1, 4'h0);
      end
   endtask

   task automatic test_single_write();
      data = 16'h00A0;
      req  = 4'b0010;
      tick();
      req = 4'b0000;
      expectAll("single_grant", 4'b0010, 4'b0000, 1'b0, 4'h0);
      tick();
      expectAll("single_ack", 4'b0010, 4'b0010, 1'b0, 4'hA);
      tick();
      expectAll("single_idle", 4'b0000, 4'b0000, 1'b1, 4'hA);
      tick();
      expectAll("single_hold", 4'b0000, 4'b0000, 1'b1, 4'hA);
   endtask

   task automatic test_fairness();
      logic [3:0] oh;
      logic [3:0] val;
      doReset();
      data = 16'h8765;
      req  = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         oh  = 4'b0001 << (j % 4);
         val = 4'(5 + (j % 4));
         tick();
         expectAll($sformatf("fair_grant_%0d", j), oh, 4'b0000, 1'b0,
                   (j == 0) ? 4'h0 : 4'(5 + ((j + 3) % 4)));
         tick();
         expectAll($sformatf("fair_ack_%0d", j), oh, oh, 1'b0, val);
         tick();
         expectAll($sformatf("fair_idle_%0d", j), 4'b0000, 4'b0000, 1'b1, val);
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap();
      doReset();
      data = 16'h0093;
      req  = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      tick();
      expectAll("wrap_first_done", 4'b0000, 4'b0000, 1'b1, 4'h9);
      // pointer is now 2; requester 0 must win over requester 1
      req = 4'b0011;
      tick();
      req = 4'b0000;
      expectAll("wrap_grant", 4'b0001, 4'b0000, 1'b0, 4'h9);
      tick();
      expectAll("wrap_ack", 4'b0001, 4'b0001, 1'b0, 4'h3);
      tick();
   endtask

   task automatic test_midop_reset();
      doReset();
      data = 16'h000C;
      req  = 4'b0001;
      tick();
      req = 4'b0000;
      expectAll("midrst_load", 4'b0001, 4'b0000, 1'b0, 4'h0);
      rst = 1'b1;
      #1;
      expectAll("midrst_async", 4'b0000, 4'b0000, 1'b1, 4'h0);
      tick();
      expectAll("midrst_held", 4'b0000, 4'b0000, 1'b1, 4'h0);
      rst = 1'b0;
      tick();
      expectAll("midrst_no_ack", 4'b0000, 4'b0000, 1'b1, 4'h0);
      data = 16'h0300;
      req  = 4'b0100;
      tick();
      req = 4'b0000;
      expectAll("midrst_next_grant", 4'b0100, 4'b0000, 1'b0, 4'h0);
      tick();
      expectAll("midrst_next_ack", 4'b0100, 4'b0100, 1'b0, 4'h3);
      tick();
      expectAll("midrst_next_idle", 4'b0000, 4'b0000, 1'b1, 4'h3);
   endtask

`ifdef SC_REG_ARBITER_LOCK_EN
   task automatic test_lock();
      doReset();
      data = 16'h0021;
      req  = 4'b0011;
      lock = 1'b1;
      tick();
      expectAll("lock_grant0", 4'b0001, 4'b0000, 1'b0, 4'h0);
      tick();
      lock = 1'b0;
      expectAll("lock_ack0", 4'b0001, 4'b0001, 1'b0, 4'h1);
      tick();
      tick();
      expectAll("lock_regrant0", 4'b0001, 4'b0000, 1'b0, 4'h1);
      tick();
      tick();
      tick();
      expectAll("unlock_grant1", 4'b0010, 4'b0000, 1'b0, 4'h1);
      tick();
      expectAll("unlock_ack1", 4'b0010, 4'b0010, 1'b0, 4'h2);
      req = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      req         = 4'b0000;
      data        = 16'h0000;
      lock        = 1'b0;
      rst         = 1'b1;
      test_reset();
      test_single_write();
      test_fairness();
      test_wrap();
      test_midop_reset();
`ifdef SC_REG_ARBITER_LOCK_EN
      test_lock();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
